led_scan_controller: RTL and testbench
======================================

Name: led_scan_controller

Overview:
Time-multiplexing controller for an N-digit common-anode 7-segment display that shares one LEDdecoder instance across all digits. Each scan slot presents one hex nibble on `char`, waits through a blanking interval, then enables that digit's anode and registers the decoded segments. A new display word is loaded with a ready/valid handshake and takes effect only at a frame boundary, so a frame never shows a torn update.

Parameters:
N_DIGITS, 4, number of digits scanned; data width is 4*N_DIGITS
DWELL_CYCLES, 50000, clk cycles a digit is lit (>=1)
BLANK_CYCLES, 500, clk cycles all anodes are off before each digit (>=1; anti-ghosting)
BLINK_FRAMES, 64, frames per blink half-period (only with SCAN_BLINK_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  scan enable; 0 blanks the display
load  input  1  valid for data_in
data_in  input  4*N_DIGITS  new display word; nibble i is shown on digit i
load_ready  output  1  pending slot empty; load accepted when load&&load_ready
char  output  4  nibble to the external LEDdecoder
led_in  input  7  decoded segments returned combinationally from LEDdecoder
seg  output  7  registered segments, active-low
an  output  N_DIGITS  registered anodes, active-low, one-hot-low while lit
frame_done  output  1  one-cycle pulse after the last digit's dwell

Behaviour:
- Reset (reset=0, async): state IDLE; display reg=0; pending empty; load_ready=1; idx=0; an=all 1; seg=7'h7F; frame_done=0; char=0.
- Registers: display (active word), pending (word+valid), idx, down-counter (width $clog2(max(DWELL,BLANK))), state.
- char = display[4*idx +: 4] at all times (combinational from registers).
- FSM:
  - IDLE: an=all 1, seg=7'h7F. On enable=1: apply pending if valid, idx=0, load BLANK_CYCLES-1, go BLANK.
  - BLANK: an=all 1, seg=7'h7F, count down. At 0: an[idx]<=0, seg<=led_in, load DWELL_CYCLES-1, go DRIVE.
  - DRIVE: seg<=led_in every cycle; count down. At 0:
    - an<=all 1.
    - If idx==N_DIGITS-1: idx<=0, frame_done<=1 for one cycle, apply pending if valid.
    - Else idx<=idx+1.
    - Load BLANK_CYCLES-1, go BLANK.
- Frame length is exactly N_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Load handshake:
  - load&&load_ready captures data_in into pending; load_ready<=0 on the next edge.
  - Applying pending to display clears it; load_ready=1 on the following cycle.
  - load while load_ready=0 is ignored (no overwrite).
  - Simultaneous accept and frame boundary: the word is captured and applied at the NEXT boundary, never the same edge.
- enable=0 in any state: next edge goes to IDLE, idx=0, an all 1, no frame_done. Pending is kept.
- Reset mid-frame: immediate return to reset values; pending is discarded.

Optional Feature:
SCAN_BLINK_EN
- With the macro defined: extra input port blink_mask [N_DIGITS-1:0] and a frame counter toggling a blink phase every BLINK_FRAMES frame_done pulses. While phase=1, a digit with blink_mask[idx]=1 keeps an[idx]=1 during DRIVE; timing and frame_done are unchanged. Phase resets to 0 on reset and on entry to IDLE.
- Without the macro: no port, no counter; behaviour as above.

Decomposition:
- Package led_scan_pkg:
  - state enum {IDLE, BLANK, DRIVE}
  - SEG_OFF=7'h7F
  - function an_onehot_low(idx)
- One sub-module, led_scan_timer: loadable down-counter with a zero flag, used for both dwell and blank.
- LEDdecoder stays external and is instantiated alongside.

Test Plan:
1. N=4, DWELL=4, BLANK=2; reset low, then high with enable=1, display=0 -> an cycles 1110,1101,1011,0111, each low for exactly 4 cycles preceded by 2 cycles of 1111; frame_done period 24 cycles; seg=decode(0) while lit.
2. Load 16'h9A3F while idle-enabled mid-frame -> load_ready drops next cycle; digits keep old value until frame_done; next frame shows F,3,A,9 on an[0..3]; load_ready returns 1 one cycle after the boundary.
3. Second load while load_ready=0 with 16'h1234 -> ignored; displayed word after the boundary is still 9A3F.
4. Assert load on the same cycle frame_done rises -> new word appears only after the following frame_done (24 cycles later).
5. Drop enable during DRIVE of digit 2 -> next cycle an=1111, seg=7F, no frame_done. Re-enable -> restart at digit 0 with a BLANK slot first.
6. Assert reset low mid-DRIVE with pending valid -> an=1111, seg=7F, load_ready=1 immediately (async); after release, display=0.

Source files
------------

// File: rtl/led_scan_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : led_scan_pkg
// Brief    : FSM encoding, segment-off pattern and anode helper for led_scan_controller
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package led_scan_pkg;

  localparam int MAX_DIGITS = 32;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] DRIVE = 2'd2;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low anode vector with only digit idx enabled; callers truncate to width.
  function automatic logic [MAX_DIGITS-1:0] an_onehot_low(input int unsigned idx);
    return ~({{(MAX_DIGITS-1){1'b0}}, 1'b1} << idx);
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_scan_timer.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : led_scan_timer
// Brief    : Loadable down-counter with zero flag, shared by blank and dwell slots
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module led_scan_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/led_scan_controller.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : led_scan_controller
// Brief    : Multiplexed common-anode 7-seg scanner with frame-aligned word loads.
//            Optional digit blinking when SCAN_BLINK_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module led_scan_controller
  import led_scan_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data_in,
  output logic                  load_ready,
  output logic [3:0]            char,
  input  logic [6:0]            led_in,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
`ifdef SCAN_BLINK_EN
  ,
  input  logic [N_DIGITS-1:0]   blink_mask
`endif
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  if (N_DIGITS < 1 || N_DIGITS > MAX_DIGITS || DWELL_CYCLES < 1 ||
      BLANK_CYCLES < 1 || BLINK_FRAMES < 1) begin : g_param_check
    $error("led_scan_controller: illegal parameter value");
  end

  logic [1:0]            state;
  logic [4*N_DIGITS-1:0] display;
  logic [4*N_DIGITS-1:0] pending;
  logic                  pending_valid;
  logic [IDX_W-1:0]      idx;
  logic                  timer_load;
  logic [CNT_W-1:0]      timer_value;
  logic                  timer_zero;
  logic                  frame_end;
  logic                  hide;

  assign load_ready = ~pending_valid;
  assign char       = display[4*idx +: 4];
  assign frame_end  = enable && (state == DRIVE) && timer_zero && (idx == LAST_IDX);

  always_comb begin
    timer_load  = 1'b0;
    timer_value = CNT_W'(BLANK_CYCLES - 1);
    if (enable) begin
      case (state)
        IDLE:  timer_load = 1'b1;
        BLANK: begin
          timer_load  = timer_zero;
          timer_value = CNT_W'(DWELL_CYCLES - 1);
        end
        DRIVE:   timer_load = timer_zero;
        default: timer_load = 1'b0;
      endcase
    end
  end

  led_scan_timer #(.WIDTH(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .value (timer_value),
    .zero  (timer_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      display       <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      idx           <= '0;
      an            <= '1;
      seg           <= SEG_OFF;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Capture only into an empty slot, so it can never collide with an apply.
      if (load && load_ready) begin
        pending       <= data_in;
        pending_valid <= 1'b1;
      end
      if (!enable) begin
        state <= IDLE;
        idx   <= '0;
        an    <= '1;
        seg   <= SEG_OFF;
      end else begin
        case (state)
          IDLE: begin
            if (pending_valid) begin
              display       <= pending;
              pending_valid <= 1'b0;
            end
            idx   <= '0;
            state <= BLANK;
          end
          BLANK: begin
            if (timer_zero) begin
              an    <= hide ? '1 : N_DIGITS'(an_onehot_low(32'(idx)));
              seg   <= led_in;
              state <= DRIVE;
            end
          end
          DRIVE: begin
            seg <= led_in;
            if (timer_zero) begin
              an    <= '1;
              seg   <= SEG_OFF;
              state <= BLANK;
              if (idx == LAST_IDX) begin
                idx        <= '0;
                frame_done <= 1'b1;
                if (pending_valid) begin
                  display       <= pending;
                  pending_valid <= 1'b0;
                end
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SCAN_BLINK_EN
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!enable) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign hide = blink_phase & blink_mask[idx];
`else
  assign hide = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_led_scan_controller.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_led_scan_controller
// Brief    : Scoreboard bench: stimulus queues expected frame words, monitor checks scan output
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_led_scan_controller;

  localparam int N     = 4;
  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int FRAME = N * (DW + BL);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic        load_ready;
  logic [3:0]  char_bus;
  logic [6:0]  led_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  assign led_in = decode(char_bus);

  led_scan_controller #(
    .N_DIGITS     (N),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .data_in    (data_in),
    .load_ready (load_ready),
    .char       (char_bus),
    .led_in     (led_in),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
`ifdef SCAN_BLINK_EN
    ,
    .blink_mask (4'b0000)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor state: handshake model, slot collection for the current frame
  int          i_cyc = -1;
  bit          mp = 1'b0;
  bit          prev_en = 1'b0;
  bit          accept, apply;
  bit          in_run = 1'b0;
  bit          first_frame = 1'b1;
  int          blank_cnt = 0;
  int          nslots = 0;
  logic [3:0]  cur_an;
  logic [6:0]  cur_seg;
  int          cur_len, cur_blank;
  bit          cur_stable;
  logic [3:0]  s_an[8];
  logic [6:0]  s_seg[8];
  int          s_len[8];
  int          s_blank[8];
  bit          s_stable[8];
  logic [15:0] word;
  logic [3:0]  exp_an;
  logic [3:0]  nib;

  always @(negedge clk) begin
    accept = 1'b0;
    apply  = 1'b0;
    if (!reset) begin
      chk("reset_an", 32'(an), 32'hF);
      chk("reset_seg", 32'(seg), 32'h7F);
      chk("reset_load_ready", 32'(load_ready), 32'd1);
      chk("reset_frame_done", 32'(frame_done), 32'd0);
      mp = 1'b0; i_cyc = -1; nslots = 0; in_run = 1'b0; blank_cnt = 0; first_frame = 1'b1;
      prev_en = 1'b0;
    end else begin
      chk("load_ready", 32'(load_ready), 32'(!mp));
      accept = load && !mp;
      if (!enable) begin
        if (!prev_en) begin
          chk("idle_an", 32'(an), 32'hF);
          chk("idle_seg", 32'(seg), 32'h7F);
          chk("idle_frame_done", 32'(frame_done), 32'd0);
        end
        i_cyc = -1; nslots = 0; in_run = 1'b0; blank_cnt = 0; first_frame = 1'b1;
      end else begin
        i_cyc++;
        chk("frame_done", 32'(frame_done), 32'((i_cyc > FRAME) && (i_cyc % FRAME == 1)));
        apply = (i_cyc % FRAME == 0);
        if (an == 4'hF) begin
          chk("blank_seg", 32'(seg), 32'h7F);
          if (in_run) begin
            if (nslots < 8) begin
              s_an[nslots] = cur_an; s_seg[nslots] = cur_seg; s_len[nslots] = cur_len;
              s_blank[nslots] = cur_blank; s_stable[nslots] = cur_stable;
            end
            nslots++;
            in_run = 1'b0;
          end
          blank_cnt++;
        end else if (!in_run) begin
          in_run = 1'b1; cur_an = an; cur_seg = seg; cur_len = 1; cur_stable = 1'b1;
          cur_blank = blank_cnt; blank_cnt = 0;
        end else begin
          cur_len++;
          if (an !== cur_an || seg !== cur_seg) cur_stable = 1'b0;
        end
        if (frame_done) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL sb_underflow: frame_done with no expected word at %0t", $time);
          end else begin
            word = exp_q.pop_front();
            chk("slot_count", 32'(nslots), 32'(N));
            for (int k = 0; k < N; k++) begin
              if (k < nslots) begin
                exp_an = ~(4'b0001 << k);
                nib    = word[4*k +: 4];
                chk("slot_an", 32'(s_an[k]), 32'(exp_an));
                chk("slot_seg", 32'(s_seg[k]), 32'(decode(nib)));
                chk("slot_dwell", 32'(s_len[k]), 32'(DW));
                chk("slot_blank", 32'(s_blank[k]), 32'((k == 0 && first_frame) ? BL + 1 : BL));
                chk("slot_stable", 32'(s_stable[k]), 32'd1);
              end
            end
          end
          nslots = 0;
          first_frame = 1'b0;
        end
      end
      if (accept) mp = 1'b1;
      else if (apply) mp = 1'b0;
      prev_en = enable;
    end
  end

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 100);
    if (!frame_done) begin
      n_checks++; n_fail++;
      $display("FAIL wait_frame: no frame_done within 100 cycles at %0t", $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; load = 1'b0; data_in = '0;
    step(3);
    reset = 1'b1;

    // Blank display scan after reset
    exp_q.push_back(16'h0000); wait_frame();
    exp_q.push_back(16'h0000); wait_frame();

    // Mid-frame load, then an ignored second load while pending is full
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h9A3F);
    step(5);  load = 1'b1; data_in = 16'h9A3F;
    step(1);  load = 1'b0;
    step(3);  load = 1'b1; data_in = 16'h1234;
    step(1);  load = 1'b0; data_in = '0;
    wait_frame(); wait_frame();

    // Load accepted on the boundary edge is applied one frame later
    exp_q.push_back(16'h9A3F);
    exp_q.push_back(16'h9A3F);
    exp_q.push_back(16'h5E07);
    step(23); load = 1'b1; data_in = 16'h5E07;
    step(1);  load = 1'b0; data_in = '0;
    wait_frame(); wait_frame(); wait_frame();

    // Drop enable during digit 2 dwell, then restart from digit 0
    step(15); enable = 1'b0;
    step(3);  enable = 1'b1;
    exp_q.push_back(16'h5E07);
    wait_frame();

    // Reset mid-dwell discards the pending word
    step(1);  load = 1'b1; data_in = 16'h1234;
    step(1);  load = 1'b0; data_in = '0;
    step(1);  reset = 1'b0;
    step(2);  reset = 1'b1;
    exp_q.push_back(16'h0000); wait_frame();
    exp_q.push_back(16'h0000); wait_frame();

    step(2);
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
